disp_scan: RTL and testbench

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 87 ++++++++
 tb/tb_disp_scan.sv | 120 ++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// Four-digit multiplexed display scanner. It holds each position for REFRESH_DIV
// cycles, starts each position with a dark guard window, and handles blink and leading-zero blanking.
module disp_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic        load,
  input  logic [3:0]  blink_en,
  input  logic        blink_pulse,
  input  logic        lz_en,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        scan_tick
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    shadow_q, shadow_d;
  logic           phase_q, phase_d;
  logic [3:0]     an_q, an_d;
  logic [3:0]     digit_q, digit_d;
  logic           tick_q, tick_d;

  logic           wrap;
  logic           guard;
  logic [3:0][3:0] nib;
  logic [3:0]     lz, blank;

  assign nib = shadow_q;

  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
    shadow_d = load ? digits : shadow_q;
    phase_d  = phase_q ^ blink_pulse;
    tick_d   = wrap;

    // Suppression cascades from the leftmost digit; position 0 always shows.
    lz[3] = lz_en && (nib[3] == 4'd0);
    lz[2] = lz[3] && (nib[2] == 4'd0);
    lz[1] = lz[2] && (nib[1] == 4'd0);
    lz[0] = 1'b0;
    blank = (blink_en & {4{phase_q}}) | lz;

    guard = (32'(cnt_q) < GUARD_CYC);

    if (guard || blank[idx_q]) begin
      an_d    = 4'hF;
      digit_d = 4'hF;
    end else begin
      an_d    = ~(4'b0001 << idx_q);
      digit_d = nib[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      shadow_q <= 16'h0000;
      phase_q  <= 1'b0;
      an_q     <= 4'hF;
      digit_q  <= 4'hF;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      digit_q  <= digit_d;
      tick_q   <= tick_d;
    end
  end

  assign an        = an_q;
  assign digit     = digit_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with REFRESH_DIV=8 and GUARD_CYC=2; each window task
// walks one 8-cycle position and checks the guard, lit and tick points against hand values.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic        load;
  logic [3:0]  blink_en;
  logic        blink_pulse;
  logic        lz_en;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        scan_tick;

  int errs = 0;
  int checks = 0;

  disp_scan #(.REFRESH_DIV(8), .GUARD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .load(load),
    .blink_en(blink_en), .blink_pulse(blink_pulse), .lz_en(lz_en),
    .digit(digit), .an(an), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Entered right after a position change (cnt=0); consumes exactly one position.
  task automatic win(input string tag, input logic [3:0] ea, input logic [3:0] ed, input bit ld_last);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) begin load = 1'b0; blink_pulse = 1'b0; end
      if (j <= 2) begin
        chk({tag, "_guard_an"}, {12'd0, an}, 16'h000F);
        chk({tag, "_guard_dig"}, {12'd0, digit}, 16'h000F);
      end
      if (j == 3 || j == 8) begin
        chk({tag, "_an"}, {12'd0, an}, {12'd0, ea});
        chk({tag, "_dig"}, {12'd0, digit}, {12'd0, ed});
      end
      if (j == 3) chk({tag, "_tick_lo"}, {15'd0, scan_tick}, 16'd0);
      if (j == 8) chk({tag, "_tick_hi"}, {15'd0, scan_tick}, 16'd1);
      if (j == 7 && ld_last) begin digits = 16'hABCD; load = 1'b1; end
      if (j == 8 && ld_last) load = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; digits = 16'h0000; load = 1'b0; blink_en = 4'b0000;
    blink_pulse = 1'b0; lz_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_dig", {12'd0, digit}, 16'h000F);
    chk("rst_tick", {15'd0, scan_tick}, 16'd0);

    // Basic scan of 1234
    rst_n = 1'b1; digits = 16'h1234; load = 1'b1;
    win("p0_1234", 4'b1110, 4'h4, 0);
    digits = 16'h9999;
    win("p1_1234", 4'b1101, 4'h3, 0);
    win("p2_1234", 4'b1011, 4'h2, 0);
    win("p3_1234", 4'b0111, 4'h1, 0);
    win("p0_noload", 4'b1110, 4'h4, 0);

    // Leading-zero suppression
    digits = 16'h0047; load = 1'b1; lz_en = 1'b1;
    win("p1_0047lz", 4'b1101, 4'h4, 0);
    win("p2_0047lz", 4'b1111, 4'hF, 0);
    win("p3_0047lz", 4'b1111, 4'hF, 0);
    win("p0_0047lz", 4'b1110, 4'h7, 0);
    lz_en = 1'b0;
    win("p1_0047", 4'b1101, 4'h4, 0);
    win("p2_0047", 4'b1011, 4'h0, 0);
    win("p3_0047", 4'b0111, 4'h0, 0);
    digits = 16'h0000; load = 1'b1; lz_en = 1'b1;
    win("p0_0000lz", 4'b1110, 4'h0, 0);
    win("p1_0000lz", 4'b1111, 4'hF, 0);
    win("p2_0000lz", 4'b1111, 4'hF, 0);
    win("p3_0000lz", 4'b1111, 4'hF, 0);

    // Blink on position 0
    digits = 16'h5678; load = 1'b1; lz_en = 1'b0; blink_en = 4'b0001; blink_pulse = 1'b1;
    win("p0_blink", 4'b1111, 4'hF, 0);
    win("p1_blink", 4'b1101, 4'h7, 0);
    win("p2_blink", 4'b1011, 4'h6, 0);
    win("p3_blink", 4'b0111, 4'h5, 0);
    blink_pulse = 1'b1;
    win("p0_unblink", 4'b1110, 4'h8, 0);

    // Load on the last cycle of a position
    win("p1_preload", 4'b1101, 4'h7, 1);
    win("p2_abcd", 4'b1011, 4'hB, 0);
    win("p3_abcd", 4'b0111, 4'hA, 0);
    win("p0_abcd", 4'b1110, 4'hD, 0);
    win("p1_abcd", 4'b1101, 4'hC, 0);

    // Asynchronous reset in the middle of position 2
    blink_en = 4'b0000;
    repeat (4) @(negedge clk);
    chk("mid_p2_an", {12'd0, an}, 16'h000B);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {12'd0, an}, 16'h000F);
    chk("async_rst_dig", {12'd0, digit}, 16'h000F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win("p0_after_rst", 4'b1110, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
